// File: rtl/decode_loop_if.sv
// Decode-stage bus: fetched instruction and execute feedback in, issue/redirect/status out.
interface decode_loop_if;
  logic        core_en;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        cell_zero;
  logic        exec_busy;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [11:0] op_arg;
  logic        branch_en;
  logic [15:0] branch_val;
  logic        stall;
  logic        halted;
  logic        err_overflow;
  logic        err_underflow;

  modport master (
    output core_en, ins, ins_pc, cell_zero, exec_busy,
    input  op_valid, op_code, op_arg, branch_en, branch_val,
           stall, halted, err_overflow, err_underflow
  );

  modport slave (
    input  core_en, ins, ins_pc, cell_zero, exec_busy,
    output op_valid, op_code, op_arg, branch_en, branch_val,
           stall, halted, err_overflow, err_underflow
  );
endinterface

// File: rtl/decode_loop.sv
// Decode stage: issues data ops to execute and resolves '[' / ']' via a PC stack,
// forward skipping, and fetch redirects followed by a fixed flush window.
module decode_loop #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FLUSH = 3
) (
  input  logic         clk,
  input  logic         rst,
  decode_loop_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;
  localparam int unsigned FL_W  = $clog2(FLUSH + 2);

  typedef enum logic [1:0] {S_RUN, S_SKIP, S_HALT} state_t;

  state_t      state_q;
  logic [SP_W-1:0]  sp_q;
  logic [15:0]      skip_q;
  logic [FL_W-1:0]  flush_q;
  logic [15:0]      stack_q [DEPTH];

  logic        op_valid_q, branch_en_q, halted_q, err_ovf_q, err_unf_q;
  logic [3:0]  op_code_q;
  logic [11:0] op_arg_q;
  logic [15:0] branch_val_q;

  logic [3:0]  op;
  logic        accept, stack_full, stack_empty, push_en;
  logic [15:0] top_inc;

  always_comb begin
    op          = bus.ins[15:12];
    accept      = bus.core_en && (bus.ins != 16'h0000) && (flush_q == '0) && (state_q != S_HALT);
    stack_full  = (sp_q == SP_W'(DEPTH));
    stack_empty = (sp_q == '0);
    top_inc     = stack_q[IDX_W'(sp_q - SP_W'(1))] + 16'd1;
    push_en     = !rst && accept && (state_q == S_RUN) && (op == 4'h7) &&
                  !bus.exec_busy && !bus.cell_zero && !stack_full;
  end

  // Loop stack storage; contents are meaningless above sp so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[IDX_W'(sp_q)] <= bus.ins_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      sp_q         <= '0;
      skip_q       <= '0;
      flush_q      <= '0;
      op_valid_q   <= 1'b0;
      op_code_q    <= '0;
      op_arg_q     <= '0;
      branch_en_q  <= 1'b0;
      branch_val_q <= '0;
      halted_q     <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
    end else begin
      op_valid_q  <= 1'b0;
      branch_en_q <= 1'b0;
      if (bus.core_en && (flush_q != '0)) flush_q <= flush_q - FL_W'(1);

      if (accept) begin
        case (state_q)
          S_RUN: begin
            case (op)
              4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                op_valid_q <= 1'b1;
                op_code_q  <= op;
                op_arg_q   <= bus.ins[11:0];
              end
              4'h7: begin
                // cell_zero is stale while execute is busy: refetch the bracket
                if (bus.exec_busy) begin
                  branch_en_q  <= 1'b1;
                  branch_val_q <= bus.ins_pc;
                  flush_q      <= FL_W'(FLUSH);
                end else if (bus.cell_zero) begin
                  state_q <= S_SKIP;
                  skip_q  <= 16'd1;
                end else if (stack_full) begin
                  err_ovf_q <= 1'b1;
                  halted_q  <= 1'b1;
                  state_q   <= S_HALT;
                end else begin
                  sp_q <= sp_q + SP_W'(1);
                end
              end
              4'h8: begin
                if (bus.exec_busy) begin
                  branch_en_q  <= 1'b1;
                  branch_val_q <= bus.ins_pc;
                  flush_q      <= FL_W'(FLUSH);
                end else if (stack_empty) begin
                  err_unf_q <= 1'b1;
                  halted_q  <= 1'b1;
                  state_q   <= S_HALT;
                end else if (!bus.cell_zero) begin
                  branch_en_q  <= 1'b1;
                  branch_val_q <= top_inc;
                  flush_q      <= FL_W'(FLUSH);
                end else begin
                  sp_q <= sp_q - SP_W'(1);
                end
              end
              4'hF: begin
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end
              default: ;
            endcase
          end
          S_SKIP: begin
            if (op == 4'h7) begin
              skip_q <= skip_q + 16'd1;
            end else if (op == 4'h8) begin
              skip_q <= skip_q - 16'd1;
              if (skip_q == 16'd1) state_q <= S_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.op_valid      = op_valid_q;
  assign bus.op_code       = op_code_q;
  assign bus.op_arg        = op_arg_q;
  assign bus.branch_en     = branch_en_q;
  assign bus.branch_val    = branch_val_q;
  assign bus.stall         = halted_q;
  assign bus.halted        = halted_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;

endmodule

// File: tb/tb_decode_loop.sv
// Table-driven bench for decode_loop: each vector carries the outputs expected after its edge.
module tb_decode_loop;

  typedef struct packed {
    logic        full;
    logic        ov;
    logic [3:0]  code;
    logic [11:0] arg;
    logic        be;
    logic [15:0] bv;
    logic        h;
    logic        eo;
    logic        eu;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] ins;
    logic [15:0] pc;
    logic        cz;
    logic        busy;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  exp_t sbq [$];
  int   tagq [$];
  vec_t tbl [$];

  decode_loop_if bus ();

  decode_loop dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic en, input logic [15:0] ins,
                              input logic [15:0] pc, input logic cz, input logic busy,
                              input logic ov, input logic [3:0] code, input logic [11:0] arg,
                              input logic be, input logic [15:0] bv,
                              input logic h, input logic eo, input logic eu);
    vec_t v;
    v.rst = r; v.en = en; v.ins = ins; v.pc = pc; v.cz = cz; v.busy = busy;
    v.exp.full = r;
    v.exp.ov = ov; v.exp.code = code; v.exp.arg = arg;
    v.exp.be = be; v.exp.bv = bv;
    v.exp.h = h; v.exp.eo = eo; v.exp.eu = eu;
    return v;
  endfunction

  function automatic vec_t run(input logic [15:0] ins, input logic [15:0] pc, input logic cz);
    return mk(1'b0, 1'b1, ins, pc, cz, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t iss(input logic [15:0] ins, input logic [3:0] code, input logic [11:0] arg);
    return mk(1'b0, 1'b1, ins, 16'h0100, 1'b0, 1'b0, 1'b1, code, arg, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t brn(input logic [15:0] ins, input logic [15:0] pc, input logic cz,
                               input logic busy, input logic [15:0] bv);
    return mk(1'b0, 1'b1, ins, pc, cz, busy, 1'b0, 4'h0, 12'h000, 1'b1, bv, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t hlt(input logic [15:0] ins, input logic eo, input logic eu);
    return mk(1'b0, 1'b1, ins, 16'h0200, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 16'h0, 1'b1, eo, eu);
  endfunction

  function automatic vec_t rstv();
    return mk(1'b1, 1'b1, 16'h1005, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check_one();
    exp_t e;
    int   tag;
    logic ok;
    if (sbq.size() != 0) begin
      e   = sbq.pop_front();
      tag = tagq.pop_front();
      ok  = (bus.op_valid == e.ov) && (bus.branch_en == e.be) &&
            (bus.halted == e.h) && (bus.stall == e.h) &&
            (bus.err_overflow == e.eo) && (bus.err_underflow == e.eu);
      if (e.ov || e.full) ok = ok && (bus.op_code == e.code) && (bus.op_arg == e.arg);
      if (e.be || e.full) ok = ok && (bus.branch_val == e.bv);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d got ov=%0b code=%h arg=%h be=%0b bv=%h h=%0b st=%0b eo=%0b eu=%0b exp ov=%0b code=%h arg=%h be=%0b bv=%h h=%0b eo=%0b eu=%0b",
                 tag, bus.op_valid, bus.op_code, bus.op_arg, bus.branch_en, bus.branch_val,
                 bus.halted, bus.stall, bus.err_overflow, bus.err_underflow,
                 e.ov, e.code, e.arg, e.be, e.bv, e.h, e.eo, e.eu);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    check_one();
    rst           = v.rst;
    bus.core_en   = v.en;
    bus.ins       = v.ins;
    bus.ins_pc    = v.pc;
    bus.cell_zero = v.cz;
    bus.exec_busy = v.busy;
    sbq.push_back(v.exp);
    tagq.push_back(vec_no);
    vec_no++;
  endtask

  initial begin
    vec_t v;
    bus.core_en = 1'b0; bus.ins = 16'h0; bus.ins_pc = 16'h0;
    bus.cell_zero = 1'b0; bus.exec_busy = 1'b0;

    // reset then first issue
    tbl.push_back(rstv());
    tbl.push_back(iss(16'h1005, 4'h1, 12'h005));
    // loop back: redirect to '[' pc + 1, three flushed ins, then issue
    tbl.push_back(run(16'h7000, 16'h0010, 1'b0));
    tbl.push_back(brn(16'h8000, 16'h0014, 1'b0, 1'b0, 16'h0011));
    tbl.push_back(iss(16'h1001, 4'h0, 12'h000)); tbl[$].exp.ov = 1'b0;
    tbl.push_back(run(16'h1002, 16'h0012, 1'b0));
    tbl.push_back(run(16'h1003, 16'h0013, 1'b0));
    tbl.push_back(iss(16'h3001, 4'h3, 12'h001));
    // loop exit pops the still-live entry
    tbl.push_back(run(16'h8000, 16'h0014, 1'b1));
    tbl.push_back(iss(16'h3001, 4'h3, 12'h001));
    // bubble, illegal, core disabled
    tbl.push_back(run(16'h0000, 16'h0016, 1'b0));
    tbl.push_back(run(16'h9123, 16'h0017, 1'b0));
    v = iss(16'h1001, 4'h0, 12'h000); v.en = 1'b0; v.exp.ov = 1'b0; tbl.push_back(v);
    // forward skip with nesting; HALT and busy ignored inside
    tbl.push_back(run(16'h7000, 16'h0020, 1'b1));
    tbl.push_back(run(16'h7000, 16'h0021, 1'b0));
    tbl.push_back(run(16'h1001, 16'h0022, 1'b0));
    tbl.push_back(run(16'hF000, 16'h0023, 1'b0));
    tbl.push_back(run(16'h8000, 16'h0024, 1'b0));
    v = run(16'h8000, 16'h0025, 1'b0); v.busy = 1'b1; tbl.push_back(v);
    tbl.push_back(iss(16'h2002, 4'h2, 12'h002));
    // replay, flush frozen by core_en=0
    tbl.push_back(brn(16'h7000, 16'h0020, 1'b1, 1'b1, 16'h0020));
    tbl.push_back(run(16'h1001, 16'h0021, 1'b0));
    v = run(16'h1001, 16'h0021, 1'b0); v.en = 1'b0; tbl.push_back(v);
    tbl.push_back(v);
    tbl.push_back(run(16'h1002, 16'h0022, 1'b0));
    tbl.push_back(run(16'h1003, 16'h0023, 1'b0));
    tbl.push_back(iss(16'h1007, 4'h1, 12'h007));
    // branch target wraps
    tbl.push_back(run(16'h7000, 16'hFFFF, 1'b0));
    tbl.push_back(brn(16'h8000, 16'h0005, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(run(16'h1001, 16'h0000, 1'b0));
    tbl.push_back(run(16'h1001, 16'h0001, 1'b0));
    tbl.push_back(run(16'h1001, 16'h0002, 1'b0));
    tbl.push_back(run(16'h8000, 16'h0005, 1'b1));
    // reset mid-flush clears flush count
    tbl.push_back(run(16'h7000, 16'h0030, 1'b0));
    tbl.push_back(brn(16'h8000, 16'h0031, 1'b0, 1'b0, 16'h0031));
    tbl.push_back(rstv());
    tbl.push_back(iss(16'h1004, 4'h1, 12'h004));
    // HALT op holds until reset
    tbl.push_back(hlt(16'hF000, 1'b0, 1'b0));
    tbl.push_back(hlt(16'h1001, 1'b0, 1'b0));
    tbl.push_back(hlt(16'h8000, 1'b0, 1'b0));
    tbl.push_back(rstv());
    // underflow on empty stack
    tbl.push_back(hlt(16'h8000, 1'b0, 1'b1));
    tbl.push_back(hlt(16'h1001, 1'b0, 1'b1));
    tbl.push_back(rstv());

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // overflow: 16 pushes fit, the 17th halts
    for (int i = 0; i < 16; i++) apply(run(16'h7000, 16'(i), 1'b0));
    apply(hlt(16'h7000, 1'b1, 1'b0));
    apply(hlt(16'h1001, 1'b1, 1'b0));
    apply(rstv());
    apply(iss(16'h6003, 4'h6, 12'h003));

    @(negedge clk);
    check_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
